col_scheduler: RTL and testbench
================================

// Module: col_scheduler
// PURPOSE
//  Consumer end of the column-select interface. Takes the per-slice column mask
//  produced for each dtheta and serialises it into one column index per handshake.
//  The frame manager fetches voxel data column by column from these indices.
//  Sits between the angle-slice source (dtheta + col mask) and the frame_manager fetch port.
// PARAMETERS
//  ROTATIONAL_RES  1024  angular slices per revolution; dtheta width = $clog2(ROTATIONAL_RES)
//  NUM_COLS        64    columns in the mask; power of 2; col index width = $clog2(NUM_COLS)
// PORTS
//  clk_in           in   1            system clock
//  rst_n_in         in   1            async reset, active-low
//  dtheta_in        in   $clog2(RR)   angle slice index for the new mask
//  dtheta_valid_in  in   1            1-cycle strobe: new slice (dtheta_in, col_indices_in) valid
//  col_indices_in   in   NUM_COLS     bit i=1 -> column i must be issued for this slice
//  col_out          out  $clog2(NC)   column index currently offered
//  dtheta_out       out  $clog2(RR)   dtheta of the slice col_out belongs to
//  col_valid_out    out  1            col_out/dtheta_out valid
//  col_ready_in     in   1            consumer accepts; transfer = valid & ready on rising edge
//  busy_out         out  1            slice in progress (state ISSUE)
//  slice_done_out   out  1            1-cycle pulse: slice fully issued (or empty)
//  overrun_out      out  1            1-cycle pulse: slice preempted with columns still pending
// BEHAVIOUR
//  Reset: all outputs 0, pending mask 0, state IDLE; async assert, sync-to-clk release.
//  All outputs registered. States: IDLE, ISSUE.
//  IDLE: on dtheta_valid_in at edge N, latch dtheta, pending = col_indices_in.
//   Non-zero mask -> ISSUE at N+1, col_valid_out=1, col_out = lowest set bit, busy_out=1.
//   Zero mask -> stay IDLE, slice_done_out pulses at N+1, col_valid_out never asserts.
//  ISSUE: col_out/dtheta_out held stable while col_valid_out & !col_ready_in.
//   On transfer: clear bit col_out in pending; next lowest set bit offered next cycle
//   (throughput 1 column/cycle with ready held high). Ascending index order always.
//   Transfer of last pending bit -> IDLE next cycle: valid=0, busy=0, slice_done_out=1.
//  Preemption: dtheta_valid_in in ISSUE with pending non-empty after this cycle's transfer
//   -> overrun_out pulses, remaining columns dropped, new slice latched; its first column
//   offered next cycle (valid stays 1, dtheta_out updates). A transfer in the same cycle counts.
//  Final transfer + dtheta_valid_in same cycle: no overrun; slice_done_out pulses and
//   new slice starts next cycle (zero new mask -> IDLE).
//  Widths: col index is $clog2(NUM_COLS) bits, no wrap; pending clear uses one-hot of col_out.
//  Reset mid-slice: everything aborted, no done/overrun pulse emitted.
// STRUCTURE
//  Package col_pkg: ROTATIONAL_RES, NUM_COLS localparams; typedefs dtheta_t, col_idx_t,
//   col_mask_t; enum sched_state_t {IDLE, ISSUE}.
//  Sub-module lowest_set_idx #(WIDTH): comb priority encoder, in mask -> idx, any.
//   Driven by next-pending value so col_out is registered with zero bubble.
//  Top: FSM + pending/dtheta/col registers, ~150-250 lines total.
// TESTING
//  1 Reset: hold rst_n_in=0 -> all outputs 0; release, no strobe -> outputs stay 0.
//  2 dtheta=5, mask all-ones, ready=1, strobe at N -> col 0..63 at N+1..N+64,
//    dtheta_out=5 throughout, slice_done at N+65, busy low at N+65.
//  3 Mask bits {2,16,63}, ready low 3 cycles on col 16 -> order 2,16,63; col_out=16 stable
//    while stalled; exactly 3 transfers, one done pulse.
//  4 Mask 0 -> col_valid_out never 1, busy stays 0, slice_done at N+1.
//  5 All-ones slice, new strobe (dtheta=6, mask bit 7) on 10th transfer cycle ->
//    overrun pulse, next offer col 7/dtheta 6, then done; cols 10..63 of old slice never seen.
//  6 Assert rst_n_in mid-slice (async, between edges) -> outputs 0 immediately; after release
//    IDLE, no done/overrun pulse.

Source files
------------

// File: rtl/col_pkg.sv
// Shared sizing, types and FSM state encoding for the column scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package col_pkg;

    localparam int ROTATIONAL_RES = 1024;
    localparam int NUM_COLS       = 64;
    localparam int DTHETA_W       = $clog2(ROTATIONAL_RES);
    localparam int COL_W          = $clog2(NUM_COLS);

    typedef logic [DTHETA_W-1:0] dtheta_t;
    typedef logic [COL_W-1:0]    col_idx_t;
    typedef logic [NUM_COLS-1:0] col_mask_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a mask, plus an any-bit flag.
// Latency: purely combinational.
// Backpressure: none.
module lowest_set_idx #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/col_scheduler.sv
// Serialises a per-slice column mask into one column index per valid/ready transfer.
// Latency: first column offered the cycle after the slice strobe; 1 column/cycle when ready.
// Backpressure: col_out/dtheta_out held while col_valid_out & !col_ready_in; new strobe preempts.
module col_scheduler
    import col_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  dtheta_t   dtheta_in,
    input  logic      dtheta_valid_in,
    input  col_mask_t col_indices_in,
    output col_idx_t  col_out,
    output dtheta_t   dtheta_out,
    output logic      col_valid_out,
    input  logic      col_ready_in,
    output logic      busy_out,
    output logic      slice_done_out,
    output logic      overrun_out
);

    sched_state_t state;
    col_mask_t    pending;
    col_mask_t    clr_mask;
    col_mask_t    pend_after;
    col_mask_t    pending_nxt;
    col_idx_t     nxt_idx;
    logic         nxt_any;
    logic         xfer;
    logic         rst_meta;
    logic         rst_n;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Remove the column accepted this cycle; a new slice strobe replaces whatever remains.
    always_comb begin
        xfer        = col_valid_out & col_ready_in;
        clr_mask    = xfer ? (col_mask_t'(1) << col_out) : '0;
        pend_after  = pending & ~clr_mask;
        pending_nxt = dtheta_valid_in ? col_indices_in : pend_after;
    end

    // Encoding the next pending mask lets col_out be registered without a bubble.
    lowest_set_idx #(
        .WIDTH (NUM_COLS)
    ) u_lowest (
        .mask (pending_nxt),
        .idx  (nxt_idx),
        .any  (nxt_any)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pending        <= '0;
            col_out        <= '0;
            dtheta_out     <= '0;
            col_valid_out  <= 1'b0;
            busy_out       <= 1'b0;
            slice_done_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            col_out       <= nxt_idx;
            col_valid_out <= nxt_any;
            busy_out      <= nxt_any;
            state         <= nxt_any ? ISSUE : IDLE;
            if (dtheta_valid_in) begin
                dtheta_out <= dtheta_in;
            end
            case (state)
                IDLE: begin
                    // An empty slice completes at once without ever offering a column.
                    slice_done_out <= dtheta_valid_in & ~|col_indices_in;
                    overrun_out    <= 1'b0;
                end
                ISSUE: begin
                    // Final column leaving completes the slice even if a new one arrives
                    // together with it; an empty incoming slice also completes at once.
                    slice_done_out <= ~|pend_after | (dtheta_valid_in & ~|col_indices_in);
                    overrun_out    <= dtheta_valid_in & |pend_after;
                end
                default: begin
                    slice_done_out <= 1'b0;
                    overrun_out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_col_scheduler.sv
// Self-checking bench for col_scheduler: table-driven slices plus stall, preemption
// and mid-slice reset sequences, with a scoreboard of expected column transfers.
module tb_col_scheduler;
    import col_pkg::*;

    logic      clk_in;
    logic      rst_n_in;
    dtheta_t   dtheta_in;
    logic      dtheta_valid_in;
    col_mask_t col_indices_in;
    col_idx_t  col_out;
    dtheta_t   dtheta_out;
    logic      col_valid_out;
    logic      col_ready_in;
    logic      busy_out;
    logic      slice_done_out;
    logic      overrun_out;

    col_scheduler dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .dtheta_in       (dtheta_in),
        .dtheta_valid_in (dtheta_valid_in),
        .col_indices_in  (col_indices_in),
        .col_out         (col_out),
        .dtheta_out      (dtheta_out),
        .col_valid_out   (col_valid_out),
        .col_ready_in    (col_ready_in),
        .busy_out        (busy_out),
        .slice_done_out  (slice_done_out),
        .overrun_out     (overrun_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        col_idx_t col;
        dtheta_t  dt;
    } xfer_t;

    typedef struct {
        dtheta_t   dt;
        col_mask_t mask;
        int        exp_cycles;
    } vec_t;

    xfer_t sb[$];
    int    checks;
    int    errors;
    int    done_cnt;
    int    ovr_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A transfer happens at the next rising edge whenever valid & ready are seen here.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (slice_done_out) done_cnt++;
            if (overrun_out)    ovr_cnt++;
            if (col_valid_out && col_ready_in) begin
                xfer_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: got col %0d dt %0d expected none", col_out, dtheta_out);
                end else begin
                    e = sb.pop_front();
                    if (col_out !== e.col || dtheta_out !== e.dt) begin
                        errors++;
                        $display("FAIL xfer: got col %0d dt %0d expected col %0d dt %0d",
                                 col_out, dtheta_out, e.col, e.dt);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_mask(input dtheta_t dt, input col_mask_t mask);
        xfer_t e;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (mask[i]) begin
                e.col = col_idx_t'(i);
                e.dt  = dt;
                sb.push_back(e);
            end
        end
    endtask

    task automatic strobe(input dtheta_t dt, input col_mask_t mask);
        dtheta_in       = dt;
        col_indices_in  = mask;
        dtheta_valid_in = 1'b1;
        tick();
        dtheta_valid_in = 1'b0;
    endtask

    task automatic run_slice(input dtheta_t dt, input col_mask_t mask, input int exp_cycles);
        int   cycles;
        int   done0;
        logic busy_ok;
        col_ready_in = 1'b1;
        push_mask(dt, mask);
        done0 = done_cnt;
        strobe(dt, mask);
        if (exp_cycles == 0) begin
            check("empty_no_valid", {63'd0, col_valid_out}, 64'd0);
        end else begin
            check("first_valid", {63'd0, col_valid_out}, 64'd1);
            check("first_dtheta", {54'd0, dtheta_out}, {54'd0, dt});
        end
        cycles  = 0;
        busy_ok = (exp_cycles == 0) ? !busy_out : busy_out;
        while (!slice_done_out && cycles < 200) begin
            tick();
            cycles++;
            if (!slice_done_out && !busy_out) busy_ok = 1'b0;
        end
        check("done_latency", 64'(cycles), 64'(exp_cycles));
        check("busy_during", {63'd0, busy_ok}, 64'd1);
        check("busy_at_done", {63'd0, busy_out}, 64'd0);
        check("valid_at_done", {63'd0, col_valid_out}, 64'd0);
        tick();
        check("done_pulse_once", 64'(done_cnt - done0), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int done0;
        int ovr0;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        ovr_cnt = 0;
        rst_n_in = 1'b0;
        dtheta_in = '0;
        dtheta_valid_in = 1'b0;
        col_indices_in = '0;
        col_ready_in = 1'b0;

        vecs[0] = '{dt: 10'd5,    mask: {64{1'b1}},             exp_cycles: 64};
        vecs[1] = '{dt: 10'd9,    mask: 64'h8000_0000_0001_0004, exp_cycles: 3};
        vecs[2] = '{dt: 10'd3,    mask: 64'h0,                   exp_cycles: 0};
        vecs[3] = '{dt: 10'd1023, mask: 64'h8000_0000_0000_0000, exp_cycles: 1};
        vecs[4] = '{dt: 10'd0,    mask: 64'h1,                   exp_cycles: 1};
        vecs[5] = '{dt: 10'd12,   mask: 64'hAAAA_AAAA_AAAA_AAAA, exp_cycles: 32};

        // Reset state, then release with no strobe.
        repeat (3) tick();
        check("rst_outputs", {col_out, dtheta_out, col_valid_out, busy_out, slice_done_out, overrun_out}, '0);
        #3 rst_n_in = 1'b1;
        repeat (5) tick();
        check("post_rst_outputs", {col_out, dtheta_out, col_valid_out, busy_out, slice_done_out, overrun_out}, '0);
        check("post_rst_no_done", 64'(done_cnt), 64'd0);

        foreach (vecs[i]) begin
            run_slice(vecs[i].dt, vecs[i].mask, vecs[i].exp_cycles);
        end

        // Stall on column 16 for three cycles.
        done0 = done_cnt;
        col_ready_in = 1'b1;
        push_mask(10'd77, 64'h8000_0000_0001_0004);
        strobe(10'd77, 64'h8000_0000_0001_0004);
        check("stall_first", {58'd0, col_out}, 64'd2);
        tick();
        check("stall_second", {58'd0, col_out}, 64'd16);
        col_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", {col_valid_out, col_out, dtheta_out}, {1'b1, 6'd16, 10'd77});
        end
        col_ready_in = 1'b1;
        tick();
        check("stall_last", {58'd0, col_out}, 64'd63);
        tick();
        check("stall_done", {63'd0, slice_done_out}, 64'd1);
        tick();
        check("stall_done_once", 64'(done_cnt - done0), 64'd1);
        check("stall_sb_drained", 64'(sb.size()), 64'd0);

        // Preemption on the tenth transfer.
        done0 = done_cnt;
        ovr0  = ovr_cnt;
        push_mask(10'd5, 64'h0000_0000_0000_03FF);
        strobe(10'd5, {64{1'b1}});
        repeat (9) tick();
        check("pre_col9", {58'd0, col_out}, 64'd9);
        push_mask(10'd6, 64'h80);
        strobe(10'd6, 64'h80);
        check("ovr_pulse", {63'd0, overrun_out}, 64'd1);
        check("ovr_new_offer", {col_valid_out, col_out, dtheta_out}, {1'b1, 6'd7, 10'd6});
        check("ovr_no_done", {63'd0, slice_done_out}, 64'd0);
        tick();
        check("ovr_then_done", {slice_done_out, overrun_out, busy_out}, {1'b1, 1'b0, 1'b0});
        tick();
        check("ovr_count", 64'(ovr_cnt - ovr0), 64'd1);
        check("ovr_done_count", 64'(done_cnt - done0), 64'd1);
        check("ovr_sb_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-slice.
        push_mask(10'd33, {64{1'b1}});
        strobe(10'd33, {64{1'b1}});
        repeat (3) tick();
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_outputs", {col_out, dtheta_out, col_valid_out, busy_out, slice_done_out, overrun_out}, '0);
        sb.delete();
        done0 = done_cnt;
        ovr0  = ovr_cnt;
        tick();
        #3 rst_n_in = 1'b1;
        repeat (6) tick();
        check("arst_idle", {col_valid_out, busy_out, slice_done_out, overrun_out}, '0);
        check("arst_no_pulses", 64'((done_cnt - done0) + (ovr_cnt - ovr0)), 64'd0);

        // Scheduler works again after reset.
        run_slice(10'd44, 64'h0000_0100_0000_0010, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
